// File: rtl/keypad_pkg.sv
// Shared constants, key codes and debounce state encoding for the 4x3 keypad scanner.
package keypad_pkg;

  localparam int NROW = 4;
  localparam int NCOL = 3;
  localparam int NKEY = NROW * NCOL;

  localparam logic [NKEY-1:0] KEY_1    = 12'h001;
  localparam logic [NKEY-1:0] KEY_2    = 12'h002;
  localparam logic [NKEY-1:0] KEY_3    = 12'h004;
  localparam logic [NKEY-1:0] KEY_4    = 12'h008;
  localparam logic [NKEY-1:0] KEY_5    = 12'h010;
  localparam logic [NKEY-1:0] KEY_6    = 12'h020;
  localparam logic [NKEY-1:0] KEY_7    = 12'h040;
  localparam logic [NKEY-1:0] KEY_8    = 12'h080;
  localparam logic [NKEY-1:0] KEY_9    = 12'h100;
  localparam logic [NKEY-1:0] KEY_0    = 12'h200;
  localparam logic [NKEY-1:0] KEY_STAR = 12'h400;
  localparam logic [NKEY-1:0] KEY_HASH = 12'h800;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_CHK,
    ST_HELD,
    ST_RELEASE_CHK
  } keypad_state_e;

  // Rows 0..2 hold the digits in reading order; the bottom row is * 0 #.
  function automatic logic [NKEY-1:0] rc_to_code(input int row, input int col);
    logic [NKEY-1:0] code;
    if (row < 3) begin
      code = KEY_1 << (row * NCOL + col);
    end else begin
      case (col)
        0:       code = KEY_STAR;
        1:       code = KEY_0;
        default: code = KEY_HASH;
      endcase
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_matrix_scanner_if.sv
// Keypad matrix pins plus the accepted-key output bundle of the scanner.
interface keypad_matrix_scanner_if;
  import keypad_pkg::*;

  logic [NROW-1:0] row_in;
  logic [NCOL-1:0] col_out;
  logic [NKEY-1:0] key_out;
  logic            key_valid;
  logic            key_held;
  keypad_state_e   dbg_state;

  // key_valid is a one-clock strobe with no back-pressure: the consumer must
  // take key_out in that cycle; key_out/key_held stay stable while the key is held.
  modport master (
    input  row_in,
    output col_out, key_out, key_valid, key_held, dbg_state
  );

  modport slave (
    output row_in,
    input  col_out, key_out, key_valid, key_held, dbg_state
  );

endinterface

// File: rtl/keypad_debounce.sv
// Frame-rate debounce FSM: accepts a single key after DEBOUNCE_SCANS identical frames and
// releases it after DEBOUNCE_SCANS frames that no longer show it.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            frame_done,
  input  logic [NKEY-1:0] code,
  output logic [NKEY-1:0] key_out,
  output logic            key_valid,
  output logic            key_held,
  output keypad_state_e   dbg_state
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  keypad_state_e   state_q, state_d;
  logic [NKEY-1:0] cand_q, cand_d;
  logic [NKEY-1:0] key_q, key_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            valid_q, valid_d;
  logic            held_q, held_d;
  logic [CW-1:0]   cnt_inc;

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    held_d  = held_q;
    valid_d = 1'b0;

    if (frame_done) begin
      unique case (state_q)
        ST_IDLE: begin
          if (code != '0) begin
            cand_d = code;
            cnt_d  = CNT_ONE;
            if (DEBOUNCE_SCANS == 1) begin
              key_d   = code;
              valid_d = 1'b1;
              held_d  = 1'b1;
              cnt_d   = '0;
              state_d = ST_HELD;
            end else begin
              state_d = ST_PRESS_CHK;
            end
          end
        end
        ST_PRESS_CHK: begin
          if (code == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              key_d   = cand_q;
              valid_d = 1'b1;
              held_d  = 1'b1;
              cnt_d   = '0;
              state_d = ST_HELD;
            end
          end else if (code == '0) begin
            cand_d  = '0;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            // A different single key restarts the candidate without leaving the check.
            cand_d = code;
            cnt_d  = CNT_ONE;
          end
        end
        ST_HELD: begin
          if (code != key_q) begin
            cnt_d = CNT_ONE;
            if (DEBOUNCE_SCANS == 1) begin
              key_d   = '0;
              held_d  = 1'b0;
              cand_d  = '0;
              cnt_d   = '0;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_RELEASE_CHK;
            end
          end
        end
        ST_RELEASE_CHK: begin
          if (code == key_q) begin
            cnt_d   = '0;
            state_d = ST_HELD;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              key_d   = '0;
              held_d  = 1'b0;
              cand_d  = '0;
              cnt_d   = '0;
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cand_q  <= '0;
      key_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end

  assign key_out   = key_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;
  assign dbg_state = state_q;

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x3 keypad scanner: synchronizes rows, strobes columns, builds a frame and decodes it
// into a single-key code that feeds the debounce FSM.
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  keypad_matrix_scanner_if.master kp
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

  logic [NROW-1:0]            row_s1_q, row_s2_q;
  logic [DW-1:0]              dwell_q, dwell_d;
  logic [NCOL-1:0]            col_q, col_d;
  logic [NCOL-1:0][NROW-1:0]  frame_q, frame_d;
  logic                       frame_done_q, frame_done_d;
  logic                       sample;
  logic [NKEY-1:0]            code_map, code;

  assign sample = (dwell_q == DWELL_LAST);

  always_comb begin
    dwell_d      = sample ? '0 : dwell_q + 1'b1;
    col_d        = sample ? {col_q[NCOL-2:0], col_q[NCOL-1]} : col_q;
    frame_done_d = sample && col_q[NCOL-1];
    frame_d      = frame_q;
    // Sync latency is two clocks, so the last dwell clock still sees rows of this column.
    if (sample) begin
      for (int c = 0; c < NCOL; c++) begin
        if (col_q[c]) frame_d[c] = row_s2_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_s1_q     <= '0;
      row_s2_q     <= '0;
      dwell_q      <= '0;
      col_q        <= 3'b001;
      frame_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      row_s1_q     <= kp.row_in;
      row_s2_q     <= row_s1_q;
      dwell_q      <= dwell_d;
      col_q        <= col_d;
      frame_q      <= frame_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Ghosting and multi-key frames both show more than one bit and decode to no key.
  always_comb begin
    code_map = '0;
    for (int r = 0; r < NROW; r++) begin
      for (int c = 0; c < NCOL; c++) begin
        if (frame_q[c][r]) code_map = code_map | rc_to_code(r, c);
      end
    end
    code = ((code_map != '0) && ((code_map & (code_map - 1'b1)) == '0)) ? code_map : '0;
  end

  assign kp.col_out = col_q;

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .frame_done (frame_done_q),
    .code       (code),
    .key_out    (kp.key_out),
    .key_valid  (kp.key_valid),
    .key_held   (kp.key_held),
    .dbg_state  (kp.dbg_state)
  );

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for the keypad scanner: a matrix model drives rows from col_out and a
// pressed-key mask; a monitor checks every key_valid pulse against an expected queue.
module tb_keypad_matrix_scanner;
  import keypad_pkg::*;

  logic            clk;
  logic            rst;
  logic [NKEY-1:0] pressed;
  logic [NKEY-1:0] exp_q[$];
  int              n_checks;
  int              n_pass;
  int              pulse_cnt;

  keypad_matrix_scanner_if kp_if();

  keypad_matrix_scanner #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp_if.master)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- matrix model ----------------
  function automatic int key_idx(input int r, input int c);
    if (r < 3) return r * 3 + c;
    if (c == 0) return 10;
    if (c == 1) return 9;
    return 11;
  endfunction

  always_comb begin
    kp_if.row_in = '0;
    for (int r = 0; r < NROW; r++) begin
      for (int c = 0; c < NCOL; c++) begin
        if (kp_if.col_out[c] && pressed[key_idx(r, c)]) kp_if.row_in[r] = 1'b1;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard monitor: every key_valid pulse must match the head of exp_q.
  always @(negedge clk) begin
    if (!rst && kp_if.key_valid) begin
      pulse_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {20'd0, kp_if.key_out}, 32'd0);
      end else begin
        logic [NKEY-1:0] e;
        e = exp_q.pop_front();
        check("pulse_key", {20'd0, kp_if.key_out}, {20'd0, e});
        check("pulse_held", {31'd0, kp_if.key_held}, 32'd1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_pulse(input string name, input int max, output int cyc);
    int start;
    start = pulse_cnt;
    cyc   = 0;
    while (pulse_cnt == start && cyc < max) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({name, "_pulse_seen"}, {31'd0, pulse_cnt != start}, 32'd1);
  endtask

  task automatic wait_release(input string name, input int max, output int cyc);
    cyc = 0;
    while (kp_if.key_held && cyc < max) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({name, "_released"}, {31'd0, kp_if.key_held}, 32'd0);
  endtask

  task automatic idle_clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    int p0;
    int guard;

    n_checks  = 0;
    n_pass    = 0;
    pulse_cnt = 0;
    pressed   = '0;
    rst       = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_col", {29'd0, kp_if.col_out}, 32'h1);
    check("rst_key", {20'd0, kp_if.key_out}, 32'h0);
    check("rst_valid", {31'd0, kp_if.key_valid}, 32'h0);
    check("rst_held", {31'd0, kp_if.key_held}, 32'h0);
    check("rst_state", 32'(kp_if.dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("col_dwell3", {29'd0, kp_if.col_out}, 32'h1);
    @(posedge clk);
    #1;
    check("col_step", {29'd0, kp_if.col_out}, 32'h2);

    // Steady '5'
    @(negedge clk);
    exp_q.push_back(KEY_5);
    pressed = KEY_5;
    wait_pulse("press5", 80, cyc);
    check("press5_not_early", {31'd0, cyc >= 24}, 32'd1);
    check("press5_key", {20'd0, kp_if.key_out}, {20'd0, KEY_5});
    p0 = pulse_cnt;
    idle_clocks(100);
    check("press5_no_repeat", pulse_cnt, p0);
    check("press5_held", {31'd0, kp_if.key_held}, 32'd1);
    pressed = '0;
    wait_release("rel5", 80, cyc);
    check("rel5_key", {20'd0, kp_if.key_out}, 32'd0);
    idle_clocks(40);

    // Bounce on '#', aligned so the bouncy samples never give three matches
    guard = 0;
    while (kp_if.col_out != 3'b100 && guard < 20) begin @(negedge clk); guard++; end
    while (kp_if.col_out == 3'b100 && guard < 40) begin @(negedge clk); guard++; end
    p0 = pulse_cnt;
    for (int i = 0; i < 6; i++) begin
      pressed = (i % 2 == 0) ? KEY_HASH : '0;
      idle_clocks(5);
    end
    check("bounce_no_pulse", pulse_cnt, p0);
    exp_q.push_back(KEY_HASH);
    pressed = KEY_HASH;
    wait_pulse("hash", 80, cyc);
    check("hash_key", {20'd0, kp_if.key_out}, {20'd0, KEY_HASH});
    idle_clocks(40);
    check("hash_single_pulse", pulse_cnt, p0 + 1);
    pressed = '0;
    wait_release("relhash", 80, cyc);
    idle_clocks(40);

    // Ghost: '1' and '9' together
    p0 = pulse_cnt;
    @(negedge clk);
    pressed = KEY_1 | KEY_9;
    idle_clocks(120);
    check("ghost_no_pulse", pulse_cnt, p0);
    check("ghost_key", {20'd0, kp_if.key_out}, 32'd0);
    check("ghost_held", {31'd0, kp_if.key_held}, 32'd0);
    check("ghost_state", 32'(kp_if.dbg_state), 32'(ST_IDLE));
    pressed = '0;
    idle_clocks(40);

    // Rollover: '*' held, then '0' pressed as '*' released
    p0 = pulse_cnt;
    exp_q.push_back(KEY_STAR);
    pressed = KEY_STAR;
    wait_pulse("star", 80, cyc);
    check("star_key", {20'd0, kp_if.key_out}, {20'd0, KEY_STAR});
    idle_clocks(30);
    exp_q.push_back(KEY_0);
    pressed = KEY_0;
    wait_release("rollover", 80, cyc);
    check("rollover_rel_delay", {31'd0, cyc >= 24}, 32'd1);
    check("rollover_rel_key", {20'd0, kp_if.key_out}, 32'd0);
    check("rollover_no_rel_pulse", pulse_cnt, p0 + 1);
    wait_pulse("zero", 80, cyc);
    check("zero_fresh_debounce", {31'd0, cyc >= 24}, 32'd1);
    check("zero_key", {20'd0, kp_if.key_out}, {20'd0, KEY_0});
    check("rollover_two_pulses", pulse_cnt, p0 + 2);
    pressed = '0;
    wait_release("relzero", 80, cyc);
    idle_clocks(40);

    // Reset in the middle of PRESS_CHK after two matching frames
    p0 = pulse_cnt;
    @(negedge clk);
    pressed = KEY_5;
    guard = 0;
    while (kp_if.dbg_state != ST_PRESS_CHK && guard < 60) begin @(negedge clk); guard++; end
    check("midrst_reached_chk", 32'(kp_if.dbg_state), 32'(ST_PRESS_CHK));
    idle_clocks(12);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_col", {29'd0, kp_if.col_out}, 32'h1);
    check("midrst_key", {20'd0, kp_if.key_out}, 32'd0);
    check("midrst_held", {31'd0, kp_if.key_held}, 32'd0);
    check("midrst_state", 32'(kp_if.dbg_state), 32'(ST_IDLE));
    check("midrst_no_pulse", pulse_cnt, p0);
    exp_q.push_back(KEY_5);
    wait_pulse("midrst", 80, cyc);
    check("midrst_full_count", {31'd0, cyc >= 30}, 32'd1);
    check("midrst_key_after", {20'd0, kp_if.key_out}, {20'd0, KEY_5});
    pressed = '0;
    wait_release("midrst_rel", 80, cyc);
    idle_clocks(20);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
